// File: rtl/sipo_stream.sv
// sipo_stream: serial-in/parallel-out packer with valid/ready on both sides.
// Packs DATA_OUT_WIDTH/DATA_IN_WIDTH input beats into one registered output
// word, with output backpressure and selectable lane order.
// Optional feature macro: SIPO_FLUSH_EN adds flush/flush_ready so that a
// partial word can be emitted early.
module sipo_stream #(
  parameter int unsigned DATA_IN_WIDTH  = 16,
  parameter int unsigned DATA_OUT_WIDTH = 64,
  parameter bit          MSB_FIRST      = 1'b0,
  localparam int unsigned NUM_SHIFTS    = DATA_OUT_WIDTH / DATA_IN_WIDTH,
  localparam int unsigned CNT_W         = $clog2(NUM_SHIFTS) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]          out_count
`ifdef SIPO_FLUSH_EN
  ,
  input  logic                      flush,
  output logic                      flush_ready
`endif
);

  // Reject output widths that are not a whole number of beats
  if (DATA_OUT_WIDTH % DATA_IN_WIDTH != 0) begin : g_width_check
    $error("sipo_stream: DATA_OUT_WIDTH must be a multiple of DATA_IN_WIDTH");
  end

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SHIFTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SHIFTS - 1);

  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic [DATA_OUT_WIDTH-1:0] asm_q;
  logic [DATA_OUT_WIDTH-1:0] asm_nxt;
  logic [DATA_OUT_WIDTH-1:0] asm_wr;
  logic                      out_valid_nxt;
  logic [DATA_OUT_WIDTH-1:0] data_out_nxt;
  logic [CNT_W-1:0]          out_count_nxt;
  logic [CNT_W-1:0]          beat_idx;
  logic [CNT_W-1:0]          lane_pos;
  logic                      full;
  logic                      slot_free;
  logic                      accept;

  // Handshake terms; in_ready deliberately follows out_ready combinationally
  always_comb begin
    full      = (cnt == CNT_FULL);
    slot_free = !out_valid || out_ready;
    in_ready  = reset_n && (!full || slot_free);
    accept    = in_valid && in_ready;
  end

`ifdef SIPO_FLUSH_EN
  // A flush can only be honoured into a free slot and never while full
  always_comb begin
    flush_ready = reset_n && slot_free && !full;
  end
`endif

  // Assembly image with the incoming beat written into its lane; a full
  // register is being emptied whenever a beat can be accepted, so the beat
  // then starts a fresh word in lane 0
  always_comb begin
    beat_idx = full ? '0 : cnt;
    lane_pos = MSB_FIRST ? (CNT_LAST - beat_idx) : beat_idx;
    asm_wr   = full ? '0 : asm_q;
    if (accept) begin
      for (int unsigned i = 0; i < NUM_SHIFTS; i++) begin
        if (CNT_W'(i) == lane_pos) begin
          asm_wr[i*DATA_IN_WIDTH +: DATA_IN_WIDTH] = data_in;
        end
      end
    end
  end

  // Next-state: counter, assembly register and output register
  always_comb begin
    cnt_nxt       = cnt;
    asm_nxt       = asm_q;
    out_valid_nxt = out_valid && !out_ready;
    data_out_nxt  = data_out;
    out_count_nxt = out_count;

    if (full) begin
      if (slot_free) begin
        out_valid_nxt = 1'b1;
        data_out_nxt  = asm_q;
        out_count_nxt = CNT_FULL;
        asm_nxt       = asm_wr;
        cnt_nxt       = accept ? CNT_W'(1) : '0;
      end
    end else if (accept && (cnt == CNT_LAST) && slot_free) begin
      out_valid_nxt = 1'b1;
      data_out_nxt  = asm_wr;
      out_count_nxt = CNT_FULL;
      asm_nxt       = '0;
      cnt_nxt       = '0;
    end
`ifdef SIPO_FLUSH_EN
    else if (flush && flush_ready && ((cnt != '0) || accept)) begin
      out_valid_nxt = 1'b1;
      data_out_nxt  = asm_wr;
      out_count_nxt = cnt + CNT_W'(accept);
      asm_nxt       = '0;
      cnt_nxt       = '0;
    end
`endif
    else if (accept) begin
      asm_nxt = asm_wr;
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // State and output registers; reset drops any partial word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      asm_q     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_count <= '0;
    end else begin
      cnt       <= cnt_nxt;
      asm_q     <= asm_nxt;
      out_valid <= out_valid_nxt;
      data_out  <= data_out_nxt;
      out_count <= out_count_nxt;
    end
  end

endmodule
